// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU datapath edge blocks.
package tpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_RES = 4;
    localparam int unsigned SEL_W   = $clog2(NUM_RES);

    // Byte-lane selector stored per element: which half the next read returns.
    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    typedef enum logic {
        RO_EMPTY,
        RO_FULL
    } ro_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; a held-high input yields one pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic sig_d;

    // Next history value is simply the current input.
    always_comb begin
        sig_d = sig_i;
    end

    // History register for the edge compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/result_readout.sv
// Captures matrix-multiply results and serves them to the host one byte per read strobe.
module result_readout
    import tpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      result_valid,
    input  logic [NUM_RES*DATA_W-1:0] results,
    input  logic                      output_en,
    input  logic [SEL_W-1:0]          output_sel,
    output logic [7:0]                out_data,
    output logic                      done,
    output logic                      overrun
);

    // Byte-lane split below assumes exactly two bytes per element.
    if (DATA_W != 16) begin : g_width_check
        $error("result_readout supports DATA_W == 16 only");
    end

    ro_state_e                        state_q, state_d;
    logic [NUM_RES-1:0][DATA_W-1:0]   buf_q, buf_d;
    logic [NUM_RES-1:0]               phase_q, phase_d;
    logic [NUM_RES-1:0]               mask_q, mask_d;
    logic [7:0]                       out_data_q, out_data_d;
    logic                             overrun_q, overrun_d;
    logic                             rd;
    logic                             final_rd;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (output_en),
        .rise_o (rd)
    );

    // Next-state: serve the read first, then decide whether a new result can be captured.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        phase_d    = phase_q;
        mask_d     = mask_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;

        if (rd) begin
            if (state_q == RO_FULL) begin
                if (phase_q[output_sel] == LO) begin
                    out_data_d          = buf_q[output_sel][7:0];
                    phase_d[output_sel] = HI;
                end else begin
                    out_data_d          = buf_q[output_sel][15:8];
                    phase_d[output_sel] = LO;
                    mask_d[output_sel]  = 1'b1;
                end
            end else begin
                out_data_d = 8'h00;
            end
        end

        // Only a read can complete the mask, so this is the draining read itself.
        final_rd = (state_q == RO_FULL) && (&mask_d);
        if (final_rd) begin
            state_d = RO_EMPTY;
        end

        if (result_valid) begin
            if ((state_q == RO_EMPTY) || final_rd) begin
                for (int k = 0; k < NUM_RES; k++) begin
                    buf_d[k] = results[k*DATA_W +: DATA_W];
                end
                phase_d = '0;
                mask_d  = '0;
                state_d = RO_FULL;
                if (state_q == RO_EMPTY) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RO_EMPTY;
            buf_q      <= '0;
            phase_q    <= '0;
            mask_q     <= '0;
            out_data_q <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            phase_q    <= phase_d;
            mask_q     <= mask_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data = out_data_q;
    assign done     = (state_q == RO_FULL);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_result_readout.sv
// Self-checking bench for result_readout against a behavioural read-count model.
module tb_result_readout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        result_valid;
    logic [63:0] results;
    logic        output_en;
    logic [1:0]  output_sel;
    logic [7:0]  out_data;
    logic        done;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    // Model: whether results are held, the held values, and how many reads each element had.
    bit         m_full;
    bit         m_ovr;
    bit         m_prev;
    logic [7:0] m_out;
    int         m_val [4];
    int         m_cnt [4];

    always #5 clk = ~clk;

    result_readout dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_valid (result_valid),
        .results      (results),
        .output_en    (output_en),
        .output_sel   (output_sel),
        .out_data     (out_data),
        .done         (done),
        .overrun      (overrun)
    );

    function automatic void model_reset();
        m_full = 0;
        m_ovr  = 0;
        m_prev = 0;
        m_out  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            m_val[k] = 0;
            m_cnt[k] = 0;
        end
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_step();
        bit rd;
        bit all_read;
        bit final_rd;
        int k;
        rd       = output_en && !m_prev;
        m_prev   = output_en;
        final_rd = 0;
        if (rd) begin
            if (!m_full) begin
                m_out = 8'h00;
            end else begin
                k        = int'(output_sel);
                m_out    = 8'((m_val[k] >> (8 * (m_cnt[k] % 2))) & 255);
                m_cnt[k] = m_cnt[k] + 1;
                all_read = 1;
                for (int j = 0; j < 4; j++) if (m_cnt[j] < 2) all_read = 0;
                final_rd = all_read;
            end
        end
        if (result_valid) begin
            if (!m_full || final_rd) begin
                if (!m_full) m_ovr = 0;
                m_full = 1;
                for (int j = 0; j < 4; j++) begin
                    m_val[j] = int'(results[j*16 +: 16]);
                    m_cnt[j] = 0;
                end
            end else begin
                m_ovr = 1;
            end
        end else if (final_rd) begin
            m_full = 0;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // One host read: strobe high for a cycle, then low with a scrambled select.
    task automatic pulse(input logic [1:0] s);
        output_en  = 1'b1;
        output_sel = s;
        tick();
        output_en  = 1'b0;
        output_sel = 2'($urandom);
        tick();
    endtask

    task automatic capture(input logic [63:0] v);
        results      = v;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        results      = {$urandom, $urandom};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && m_full; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (m_full && m_cnt[k] < 2) begin
                    pulse(2'(k));
                end
            end
        end
    endtask

    task automatic test_reset();
        result_valid = 1'b0;
        results      = '0;
        output_en    = 1'b0;
        output_sel   = 2'd0;
        apply_reset();
        total++;
        if ({out_data, done, overrun} !== 10'h000) begin
            bad++;
            $display("FAIL reset_state: got out=%h done=%b ovr=%b want 00/0/0", out_data, done, overrun);
        end
        pulse(2'd0);
        total++;
        if ({out_data, done, overrun} !== 10'h000) begin
            bad++;
            $display("FAIL reset_read: got out=%h done=%b ovr=%b want 00/0/0", out_data, done, overrun);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4];
        logic [1:0] sels  [4];
        exp_b = '{8'h11, 8'h11, 8'h44, 8'h44};
        sels  = '{2'd0, 2'd0, 2'd3, 2'd3};
        capture(64'h4444_3333_2222_1111);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL basic_done: got %b want 1", done);
        end
        for (int i = 0; i < 4; i++) begin
            pulse(sels[i]);
            total++;
            if (out_data !== exp_b[i] || out_data !== m_out) begin
                bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i, out_data, exp_b[i]);
            end
        end
        drain();
    endtask

    task automatic test_order();
        logic [7:0] exp_b [8];
        logic [1:0] sels  [8];
        exp_b = '{8'hFE, 8'hCA, 8'h34, 8'h12, 8'hAD, 8'hDE, 8'hEF, 8'hBE};
        sels  = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd2, 2'd2};
        capture(64'hDEAD_BEEF_CAFE_1234);
        for (int i = 0; i < 8; i++) begin
            pulse(sels[i]);
            total++;
            if (out_data !== exp_b[i]) begin
                bad++;
                $display("FAIL order_byte%0d: got %h want %h", i, out_data, exp_b[i]);
            end
            total++;
            if (done !== (i < 7)) begin
                bad++;
                $display("FAIL order_done%0d: got %b want %b", i, done, (i < 7));
            end
        end
        pulse(2'd0);
        total++;
        if (out_data !== 8'h00) begin
            bad++;
            $display("FAIL order_after_drain: got %h want 00", out_data);
        end
    endtask

    task automatic test_hold();
        logic [63:0] v;
        v = {$urandom, $urandom};
        capture(v);
        output_en  = 1'b1;
        output_sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_data !== v[23:16]) begin
                bad++;
                $display("FAIL hold_cycle%0d: got %h want %h", i, out_data, v[23:16]);
            end
        end
        output_en = 1'b0;
        tick();
        pulse(2'd1);
        total++;
        if (out_data !== v[31:24]) begin
            bad++;
            $display("FAIL hold_next_hi: got %h want %h", out_data, v[31:24]);
        end
        drain();
    endtask

    task automatic test_overrun();
        logic [63:0] v;
        v = 64'h0102_0304_0506_0708;
        capture(v);
        pulse(2'd2);
        capture(64'hFFFF_EEEE_DDDD_CCCC);
        total++;
        if (overrun !== 1'b1 || done !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got ovr=%b done=%b want 1/1", overrun, done);
        end
        pulse(2'd2);
        total++;
        if (out_data !== 8'h03) begin
            bad++;
            $display("FAIL overrun_old_hi: got %h want 03", out_data);
        end
        pulse(2'd3);
        total++;
        if (out_data !== 8'h02) begin
            bad++;
            $display("FAIL overrun_old_lo: got %h want 02", out_data);
        end
        drain();
        total++;
        if (overrun !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL overrun_sticky: got ovr=%b done=%b want 1/0", overrun, done);
        end
        capture({$urandom, $urandom});
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        drain();
    endtask

    task automatic test_collision();
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        capture(a);
        for (int k = 0; k < 3; k++) begin
            pulse(2'(k));
            pulse(2'(k));
        end
        pulse(2'd3);
        // Final draining read coincides with a new result.
        output_en    = 1'b1;
        output_sel   = 2'd3;
        results      = b;
        result_valid = 1'b1;
        tick();
        output_en    = 1'b0;
        result_valid = 1'b0;
        total++;
        if (out_data !== a[63:56] || done !== 1'b1 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL collide_final: got out=%h done=%b ovr=%b want %h/1/0",
                     out_data, done, overrun, a[63:56]);
        end
        tick();
        pulse(2'd0);
        total++;
        if (out_data !== b[7:0]) begin
            bad++;
            $display("FAIL collide_new_lo: got %h want %h", out_data, b[7:0]);
        end
        // Non-final read plus result: read served from old data, result counts as overrun.
        output_en    = 1'b1;
        output_sel   = 2'd0;
        results      = {$urandom, $urandom};
        result_valid = 1'b1;
        tick();
        output_en    = 1'b0;
        result_valid = 1'b0;
        total++;
        if (out_data !== b[15:8] || overrun !== 1'b1) begin
            bad++;
            $display("FAIL collide_nonfinal: got out=%h ovr=%b want %h/1", out_data, overrun, b[15:8]);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            result_valid = ($urandom_range(0, 7) == 0);
            results      = {$urandom, $urandom};
            output_en    = 1'($urandom);
            output_sel   = 2'($urandom);
            tick();
            total++;
            if (out_data !== m_out || done !== m_full || overrun !== m_ovr) begin
                bad++;
                errs++;
                if (errs <= 10) begin
                    $display("FAIL random_cycle%0d: got out=%h done=%b ovr=%b want %h/%b/%b",
                             i, out_data, done, overrun, m_out, m_full, m_ovr);
                end
            end
        end
        result_valid = 1'b0;
        output_en    = 1'b0;
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        capture(64'h1234_5678_9ABC_DEF0);
        pulse(2'd0);
        pulse(2'd0);
        pulse(2'd1);
        rst_n = 1'b0;
        #2;
        model_reset();
        total++;
        if (done !== 1'b0 || out_data !== 8'h00 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got out=%h done=%b ovr=%b want 00/0/0",
                     out_data, done, overrun);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse(2'd1);
        total++;
        if (out_data !== 8'h00 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_read: got out=%h done=%b want 00/0", out_data, done);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_order();
        test_hold();
        test_overrun();
        test_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
